// File: rtl/ue14500_pkg.sv
// Definitions shared between the UE14500 ICU and its program sequencer:
// opcode encodings, default address width and the sequencer state type.
package ue14500_pkg;

    localparam int UE_AW = 4;

    localparam logic [3:0] OP_NOP0 = 4'h0;
    localparam logic [3:0] OP_LD   = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_ONE  = 4'h4;
    localparam logic [3:0] OP_NAND = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_STO  = 4'h8;
    localparam logic [3:0] OP_STOC = 4'h9;
    localparam logic [3:0] OP_IEN  = 4'hA;
    localparam logic [3:0] OP_OEN  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_RTN  = 4'hD;
    localparam logic [3:0] OP_SKZ  = 4'hE;
    localparam logic [3:0] OP_NOPF = 4'hF;

    typedef enum logic {
        SEQ_RUN  = 1'b0,
        SEQ_HALT = 1'b1
    } seq_state_t;

endpackage

// File: rtl/ue14500_ret_stack.sv
// Return-address LIFO as a shift register: entry 0 is always the top.
// A push while full drops the oldest entry; a pop while empty yields address 0.
module ue14500_ret_stack
    import ue14500_pkg::*;
#(
    parameter int AW    = UE_AW,
    parameter int DEPTH = 2
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         push,
    input  logic                         pop,
    input  logic [AW-1:0]                push_data,
    output logic [AW-1:0]                top,
    output logic [$clog2(DEPTH+1)-1:0]   sp,
    output logic                         ovf_strobe,
    output logic                         unf_strobe
);

    localparam int SPW = $clog2(DEPTH + 1);

    logic [AW-1:0]  entry_reg  [DEPTH];
    logic [AW-1:0]  entry_next [DEPTH];
    logic [SPW-1:0] sp_reg;
    logic [SPW-1:0] sp_next;
    logic           full;
    logic           empty;

    assign full       = (sp_reg == SPW'(DEPTH));
    assign empty      = (sp_reg == '0);
    assign ovf_strobe = push & full;
    assign unf_strobe = pop & ~push & empty;
    assign top        = empty ? '0 : entry_reg[0];
    assign sp         = sp_reg;

    // Vacated slots are refilled with zero so unused entries never hold stale addresses.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [AW-1:0] push_src;
        logic [AW-1:0] pop_src;
        if (gi == 0) begin : g_top
            assign push_src = push_data;
        end else begin : g_lower
            assign push_src = entry_reg[gi-1];
        end
        if (gi == DEPTH - 1) begin : g_last
            assign pop_src = '0;
        end else begin : g_inner
            assign pop_src = entry_reg[gi+1];
        end
        assign entry_next[gi] = push ? push_src : (pop ? pop_src : entry_reg[gi]);
    end

    always_comb begin
        sp_next = sp_reg;
        if (push && !full) begin
            sp_next = sp_reg + 1'b1;
        end else if (!push && pop && !empty) begin
            sp_next = sp_reg - 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_reg[i] <= '0;
            end
            sp_reg <= '0;
        end else begin
            entry_reg <= entry_next;
            sp_reg    <= sp_next;
        end
    end

endmodule

// File: rtl/ue14500_seq.sv
// Program sequencer for the UE14500 ICU: program counter, jump/return with a
// return stack, program restart and halt/resume driven by the ICU flag pulses.
module ue14500_seq
    import ue14500_pkg::*;
#(
    parameter int AW    = UE_AW,
    parameter int DEPTH = 2
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         JMP,
    input  logic                         RTN,
    input  logic                         FL0,
    input  logic                         FLF,
    input  logic [AW-1:0]                TGT_IN,
    input  logic                         RUN,
    output logic [AW-1:0]                ADDR,
    output logic                         HALT,
    output logic [$clog2(DEPTH+1)-1:0]   SP,
    output logic                         OVF,
    output logic                         UNF
);

    seq_state_t    state_reg;
    logic          halt_reg;
    logic [AW-1:0] addr_reg;
    logic [AW-1:0] addr_next;
    logic [AW-1:0] addr_inc;
    logic [AW-1:0] tgt_reg;
    logic          ovf_reg;
    logic          unf_reg;
    logic          running;
    logic          stk_push;
    logic          stk_pop;
    logic [AW-1:0] stk_top;
    logic          stk_ovf;
    logic          stk_unf;

    assign running  = (state_reg == SEQ_RUN);
    assign addr_inc = addr_reg + 1'b1;
    assign stk_push = running & ~FL0 & JMP;
    assign stk_pop  = running & ~FL0 & ~JMP & RTN;

    // Flags arrive one cycle after their instruction, so the jump target is the
    // field latched on the previous edge and the return address skips the delay slot.
    always_comb begin
        addr_next = addr_reg;
        if (FL0) begin
            addr_next = addr_reg;
        end else if (JMP) begin
            addr_next = tgt_reg;
        end else if (RTN) begin
            addr_next = stk_top;
        end else if (FLF) begin
            addr_next = '0;
        end else begin
            addr_next = addr_inc;
        end
    end

    ue14500_ret_stack #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .push       (stk_push),
        .pop        (stk_pop),
        .push_data  (addr_inc),
        .top        (stk_top),
        .sp         (SP),
        .ovf_strobe (stk_ovf),
        .unf_strobe (stk_unf)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg <= SEQ_RUN;
            halt_reg  <= 1'b0;
            addr_reg  <= '0;
            tgt_reg   <= '0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else begin
            case (state_reg)
                SEQ_RUN: begin
                    addr_reg <= addr_next;
                    if (FL0) begin
                        state_reg <= SEQ_HALT;
                        halt_reg  <= 1'b1;
                    end else begin
                        tgt_reg <= TGT_IN;
                    end
                end
                SEQ_HALT: begin
                    if (RUN) begin
                        state_reg <= SEQ_RUN;
                        halt_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= SEQ_RUN;
                    halt_reg  <= 1'b0;
                end
            endcase
            ovf_reg <= ovf_reg | stk_ovf;
            unf_reg <= unf_reg | stk_unf;
        end
    end

    assign ADDR = addr_reg;
    assign HALT = halt_reg;
    assign OVF  = ovf_reg;
    assign UNF  = unf_reg;

endmodule

// File: tb/tb_ue14500_seq.sv
// Directed bench for ue14500_seq (AW=4, DEPTH=2): counting, call/return,
// stack overflow/underflow, halt/resume, restart/wrap and async reset.
module tb_ue14500_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       jmp;
    logic       rtn;
    logic       fl0;
    logic       flf;
    logic [3:0] tgt_in;
    logic       run;
    logic [3:0] addr;
    logic       halt;
    logic [1:0] sp;
    logic       ovf;
    logic       unf;

    int n_checks = 0;
    int n_pass   = 0;

    ue14500_seq #(
        .AW    (4),
        .DEPTH (2)
    ) dut (
        .CLK    (clk),
        .RST_N  (rst_n),
        .JMP    (jmp),
        .RTN    (rtn),
        .FL0    (fl0),
        .FLF    (flf),
        .TGT_IN (tgt_in),
        .RUN    (run),
        .ADDR   (addr),
        .HALT   (halt),
        .SP     (sp),
        .OVF    (ovf),
        .UNF    (unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int target);
        int n;
        n = 0;
        while (addr !== 4'(target) && n < 40) begin
            step();
            n++;
        end
        chk("run_to", 32'(addr), 32'(target));
    endtask

    initial begin
        rst_n = 1'b0; jmp = 1'b0; rtn = 1'b0; fl0 = 1'b0; flf = 1'b0;
        tgt_in = 4'd0; run = 1'b0;
        #2;
        chk("rst_addr", 32'(addr), 0);
        chk("rst_halt", 32'(halt), 0);
        chk("rst_sp",   32'(sp),   0);
        chk("rst_ovf",  32'(ovf),  0);
        chk("rst_unf",  32'(unf),  0);
        #10;
        rst_n = 1'b1;

        // Free-running count with wrap
        chk("count_0", 32'(addr), 0);
        for (int i = 1; i < 20; i++) begin
            step();
            chk($sformatf("count_%0d", i), 32'(addr), 32'(i % 16));
        end
        chk("count_halt", 32'(halt), 0);
        chk("count_sp",   32'(sp),   0);

        // Call / return
        tgt_in = 4'd9;
        step();
        chk("call_a4", 32'(addr), 4);
        jmp = 1'b1; tgt_in = 4'd0;
        step();
        jmp = 1'b0;
        chk("call_a9", 32'(addr), 9);
        chk("call_sp1", 32'(sp), 1);
        step();
        chk("call_a10", 32'(addr), 10);
        rtn = 1'b1;
        step();
        rtn = 1'b0;
        chk("ret_a5", 32'(addr), 5);
        chk("ret_sp0", 32'(sp), 0);
        chk("ret_ovf", 32'(ovf), 0);
        chk("ret_unf", 32'(unf), 0);

        // Restart to 0, then three nested calls returning to 2, 6, 11
        flf = 1'b1;
        step();
        flf = 1'b0;
        chk("flf_a0", 32'(addr), 0);
        tgt_in = 4'd4;
        step();
        jmp = 1'b1;
        step();
        jmp = 1'b0;
        chk("nest1_a4", 32'(addr), 4);
        chk("nest1_sp", 32'(sp), 1);
        tgt_in = 4'd9;
        step();
        jmp = 1'b1;
        step();
        jmp = 1'b0;
        chk("nest2_a9", 32'(addr), 9);
        chk("nest2_sp", 32'(sp), 2);
        chk("nest2_ovf", 32'(ovf), 0);
        tgt_in = 4'd13;
        step();
        jmp = 1'b1;
        step();
        jmp = 1'b0;
        chk("nest3_a13", 32'(addr), 13);
        chk("nest3_sp", 32'(sp), 2);
        chk("nest3_ovf", 32'(ovf), 1);
        chk("nest3_unf", 32'(unf), 0);
        rtn = 1'b1;
        step();
        chk("pop1_a11", 32'(addr), 11);
        chk("pop1_sp", 32'(sp), 1);
        step();
        chk("pop2_a6", 32'(addr), 6);
        chk("pop2_sp", 32'(sp), 0);
        chk("pop2_unf", 32'(unf), 0);
        step();
        rtn = 1'b0;
        chk("pop3_a0", 32'(addr), 0);
        chk("pop3_sp", 32'(sp), 0);
        chk("pop3_unf", 32'(unf), 1);
        chk("pop3_ovf", 32'(ovf), 1);

        // Halt / resume: FL0 from the instruction at 7 arrives while ADDR=8
        tgt_in = 4'd2;
        run_to(8);
        fl0 = 1'b1; tgt_in = 4'd5;
        step();
        fl0 = 1'b0;
        chk("halt_a8", 32'(addr), 8);
        chk("halt_on", 32'(halt), 1);
        for (int i = 0; i < 5; i++) begin
            jmp = i[0]; flf = ~i[0]; rtn = i[1]; tgt_in = 4'(i + 10);
            step();
            chk($sformatf("halt_hold_a%0d", i), 32'(addr), 8);
            chk($sformatf("halt_hold_h%0d", i), 32'(halt), 1);
            chk($sformatf("halt_hold_sp%0d", i), 32'(sp), 0);
        end
        jmp = 1'b0; flf = 1'b0; rtn = 1'b0; tgt_in = 4'd0;
        run = 1'b1;
        step();
        chk("resume_h0", 32'(halt), 0);
        chk("resume_a8", 32'(addr), 8);
        step();
        chk("resume_a9", 32'(addr), 9);
        run = 1'b0;
        step();
        chk("resume_a10", 32'(addr), 10);

        // Restart from the instruction at 12
        run_to(13);
        flf = 1'b1;
        step();
        flf = 1'b0;
        chk("restart_a0", 32'(addr), 0);
        step();
        chk("restart_a1", 32'(addr), 1);

        // JMP from 15 pushes 1 (wrapped delay-slot successor)
        run_to(15);
        tgt_in = 4'd4;
        step();
        chk("wrap_a0", 32'(addr), 0);
        tgt_in = 4'd0;
        jmp = 1'b1;
        step();
        jmp = 1'b0;
        chk("wrapjmp_a4", 32'(addr), 4);
        chk("wrapjmp_sp", 32'(sp), 1);
        rtn = 1'b1;
        step();
        rtn = 1'b0;
        chk("wrapret_a1", 32'(addr), 1);
        chk("wrapret_sp", 32'(sp), 0);

        // JMP flag while ADDR=15 pushes 0
        run_to(14);
        tgt_in = 4'd9;
        step();
        tgt_in = 4'd0;
        jmp = 1'b1;
        step();
        jmp = 1'b0;
        chk("push15_a9", 32'(addr), 9);
        chk("push15_sp", 32'(sp), 1);
        step();
        rtn = 1'b1;
        step();
        rtn = 1'b0;
        chk("pop15_a0", 32'(addr), 0);
        chk("pop15_sp", 32'(sp), 0);

        // Async reset in the middle of a call
        tgt_in = 4'd9;
        step();
        jmp = 1'b1;
        step();
        jmp = 1'b0;
        chk("precall_a9", 32'(addr), 9);
        chk("precall_sp", 32'(sp), 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_addr", 32'(addr), 0);
        chk("arst_sp",   32'(sp),   0);
        chk("arst_ovf",  32'(ovf),  0);
        chk("arst_unf",  32'(unf),  0);
        chk("arst_halt", 32'(halt), 0);
        step();
        chk("arst_hold", 32'(addr), 0);
        rst_n = 1'b1;
        step();
        chk("post_rst_a1", 32'(addr), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
